fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side controller for the dual-clock FIFO. It sits in the W_CLK domain next to the FIFO storage RAM and drives that RAM's write enable and write address from a producer write request. It keeps the binary and Gray write pointers and synchronizes the read-domain Gray pointer into W_CLK. From these it generates registered full, almost-full, fill-level and sticky overflow status.

## Interface

Parameters:
- ADDR_WIDTH, 3, RAM address width; FIFO depth = 2^ADDR_WIDTH.
- SYNC_STAGES, 2, flop stages on the incoming read pointer; legal values are 2 or more.
- AFULL_LEVEL, 6, fill level at or above which W_AFULL asserts; legal range 1..2^ADDR_WIDTH.

Ports:
- W_CLK, in, 1, write-domain clock; all state updates on the rising edge.
- W_RST_n, in, 1, asynchronous active-low reset.
- W_INC, in, 1, producer write request for the current cycle.
- W_OVF_CLR, in, 1, clears W_OVF.
- R_GPTR, in, ADDR_WIDTH+1, Gray read pointer from the read domain, unsynchronized.
- W_CLK_EN, out, 1, RAM write enable = W_INC & ~W_FULL (combinational).
- W_ADDR, out, ADDR_WIDTH, RAM write address = low bits of the binary write pointer (registered).
- W_GPTR, out, ADDR_WIDTH+1, registered Gray write pointer, exported to the read domain.
- W_FULL, out, 1, registered full flag.
- W_AFULL, out, 1, registered almost-full flag.
- W_LEVEL, out, ADDR_WIDTH+1, registered fill level, range 0..2^ADDR_WIDTH.
- W_OVF, out, 1, sticky flag: a write was attempted while full.

## Operation

- **Accept rule:** a write is accepted at a rising edge when W_INC=1 and W_FULL=0.
  - On accept, wbin increments modulo 2^(ADDR_WIDTH+1).
  - W_GPTR is loaded with gray(wbin_next) = wbin_next ^ (wbin_next >> 1).
- **Read-pointer synchronizer:** R_GPTR passes through a SYNC_STAGES-deep flop chain. Only the last stage, rq_sync, is used.
- **Full:** full_next = (gray(wbin_next) == {~rq_sync[MSB:MSB-1], rq_sync[MSB-2:0]}). It is registered into W_FULL.
- **Level:** level_next = wbin_next − gray2bin(rq_sync), modulo 2^(ADDR_WIDTH+1). It is registered into W_LEVEL.
- **Almost-full:** W_AFULL is registered as (level_next >= AFULL_LEVEL).
- **Overflow:**
  - W_INC=1 while W_FULL=1 sets W_OVF. Pointers and the RAM are untouched, since W_CLK_EN=0.
  - W_OVF_CLR=1 clears W_OVF.
  - If set and clear occur in the same cycle, set wins.
- **Pessimism:** full and level are conservative because the read pointer lags. A slot freed by the reader is never reported early. Full never deasserts while the FIFO is actually full.
- **Gray safety:** W_GPTR changes at most one bit per W_CLK edge.
- **Reset (W_RST_n=0, asynchronous):**
  - wbin, W_ADDR, W_GPTR and all synchronizer stages go to 0.
  - W_FULL=0, W_AFULL=0, W_LEVEL=0, W_OVF=0.
  - W_CLK_EN follows W_INC.
  - Assertion mid-operation discards all state. The pending write is not performed on that edge.

## Timing

- **Write latency:** the RAM captures data at the same edge the write is accepted. W_ADDR, W_GPTR, W_LEVEL, W_FULL and W_AFULL reflect the new pointer immediately after that edge.
- **Filling write:** W_FULL=1 after the edge that accepts the 2^ADDR_WIDTH-th unread entry. W_CLK_EN drops to 0 in the same cycle.
- **Read-side update:** a change on R_GPTR that is stable before edge k reaches rq_sync at edge k+SYNC_STAGES−1. W_FULL, W_LEVEL and W_AFULL update at edge k+SYNC_STAGES. This is 3 edges for the default.
- **Simultaneous events:** an accepted write in the same cycle as a synchronized read-pointer advance leaves the level unchanged. The flags are recomputed from both values.
- **Wrap-around:**
  - The pointer MSB toggles every 2^ADDR_WIDTH writes.
  - W_ADDR wraps from 2^ADDR_WIDTH−1 to 0.
  - Full detection and level stay correct across any number of wraps.

## Test plan

- **Reset:** apply reset with W_INC=1, R_GPTR=0.
  - During reset, all outputs are 0 except W_CLK_EN=1.
  - After release, the first edge writes address 0.
- **Fill (defaults, R_GPTR=0):** issue 8 back-to-back writes.
  - W_GPTR goes 1,3,2,6,7,5,4,12.
  - W_AFULL rises after the 6th write.
  - W_FULL and W_LEVEL=8 appear after the 8th write.
  - The 9th request gives W_CLK_EN=0 and sets W_OVF.
- **Overflow clear:** with FIFO full, hold W_INC=1 and pulse W_OVF_CLR=1.
  - W_OVF stays 1 because set wins.
  - With W_INC=0 and W_OVF_CLR=1, W_OVF becomes 0.
- **Drain release:** with FIFO full, set R_GPTR=1.
  - W_FULL=0 and W_LEVEL=7 after exactly 3 edges; W_AFULL stays 1.
  - Set R_GPTR=3: W_LEVEL=6.
- **Wrap:** a read-domain model tracks the writer; issue 20 writes.
  - W_ADDR sequence is 0..7,0..7,0..3.
  - W_GPTR MSB toggles at the 8th and 16th writes.
  - There are no spurious full pulses.
- **Mid-operation reset:** at level 5, assert W_RST_n=0 between clock edges while W_INC=1.
  - Outputs clear asynchronously.
  - After release, writes resume at W_ADDR=0 and W_LEVEL counts from 0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: write pointers, read-pointer
// synchronizer and registered full / almost-full / level / overflow status.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                  W_CLK,
  input  logic                  W_RST_n,
  input  logic                  W_INC,
  input  logic                  W_OVF_CLR,
  input  logic [ADDR_WIDTH:0]   R_GPTR,
  output logic                  W_CLK_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   W_GPTR,
  output logic                  W_FULL,
  output logic                  W_AFULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  W_OVF
);

  localparam int PW = ADDR_WIDTH + 1;
  // Inverting the two MSBs of the read Gray pointer yields the Gray value the
  // write pointer holds exactly one full lap ahead of the reader.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] level_next;
  logic [PW-1:0] rq_sync;
  logic [PW-1:0] sync_p [SYNC_STAGES];
  logic          accept;
  logic          full_next;
  logic          afull_next;

  assign accept   = W_INC & ~W_FULL;
  assign W_CLK_EN = accept;
  assign W_ADDR   = wbin[ADDR_WIDTH-1:0];
  assign rq_sync  = sync_p[SYNC_STAGES-1];

  // Next-pointer and status computation against the synchronized read pointer
  always_comb begin
    wbin_next  = wbin + PW'(accept);
    wgray_next = bin2gray(wbin_next);
    full_next  = (wgray_next == (rq_sync ^ FULL_MASK));
    level_next = wbin_next - gray2bin(rq_sync);
    afull_next = (level_next >= PW'(AFULL_LEVEL));
  end

  // Read-pointer synchronizer chain into W_CLK
  always_ff @(posedge W_CLK or negedge W_RST_n) begin
    if (!W_RST_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
    end else begin
      sync_p[0] <= R_GPTR;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  // Pointer and status registers
  always_ff @(posedge W_CLK or negedge W_RST_n) begin
    if (!W_RST_n) begin
      wbin    <= '0;
      W_GPTR  <= '0;
      W_FULL  <= 1'b0;
      W_AFULL <= 1'b0;
      W_LEVEL <= '0;
      W_OVF   <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      W_GPTR  <= wgray_next;
      W_FULL  <= full_next;
      W_AFULL <= afull_next;
      W_LEVEL <= level_next;
      // A rejected write in the same cycle as a clear keeps the flag set
      W_OVF   <= (W_INC & W_FULL) | (W_OVF & ~W_OVF_CLR);
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl at default parameters (depth 8, 2 sync stages,
// almost-full at 6).
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       inc;
  logic       ovf_clr;
  logic [3:0] r_gptr;
  logic       clk_en;
  logic [2:0] addr;
  logic [3:0] gptr;
  logic       full;
  logic       afull;
  logic [3:0] level;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  fifo_wr_ctrl dut (
    .W_CLK     (clk),
    .W_RST_n   (rst_n),
    .W_INC     (inc),
    .W_OVF_CLR (ovf_clr),
    .R_GPTR    (r_gptr),
    .W_CLK_EN  (clk_en),
    .W_ADDR    (addr),
    .W_GPTR    (gptr),
    .W_FULL    (full),
    .W_AFULL   (afull),
    .W_LEVEL   (level),
    .W_OVF     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_clk_en"}, 32'(clk_en), 32'(inc));
    chk({tag, "_addr"},   32'(addr),   0);
    chk({tag, "_gptr"},   32'(gptr),   0);
    chk({tag, "_full"},   32'(full),   0);
    chk({tag, "_afull"},  32'(afull),  0);
    chk({tag, "_level"},  32'(level),  0);
    chk({tag, "_ovf"},    32'(ovf),    0);
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic reset_pulse();
    #3;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [3:0] fill_gray [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b1;
    inc     = 1'b1;
    ovf_clr = 1'b0;
    r_gptr  = 4'd0;

    // Reset with a write request pending
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_async");
    step();
    chk_reset_outputs("rst_hold");
    rst_n = 1'b1;
    chk("first_addr", 32'(addr), 0);
    chk("first_clk_en", 32'(clk_en), 1);

    // Fill 8 back-to-back
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("fill%0d_addr", k),  32'(addr),  32'(k % 8));
      chk($sformatf("fill%0d_gptr", k),  32'(gptr),  32'(fill_gray[k-1]));
      chk($sformatf("fill%0d_level", k), 32'(level), 32'(k));
      chk($sformatf("fill%0d_afull", k), 32'(afull), 32'(k >= 6));
      chk($sformatf("fill%0d_full", k),  32'(full),  32'(k == 8));
    end
    chk("full_clk_en", 32'(clk_en), 0);
    step();
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_gptr_hold", 32'(gptr), 12);
    chk("ovf_level_hold", 32'(level), 8);
    chk("ovf_addr_hold", 32'(addr), 0);

    // Overflow clear: set wins, then clear
    ovf_clr = 1'b1;
    step();
    chk("ovf_set_wins", 32'(ovf), 1);
    inc = 1'b0;
    step();
    chk("ovf_cleared", 32'(ovf), 0);
    ovf_clr = 1'b0;

    // Drain release through the synchronizer
    r_gptr = 4'd1;
    step();
    chk("drain_e1_full", 32'(full), 1);
    step();
    chk("drain_e2_full", 32'(full), 1);
    chk("drain_e2_level", 32'(level), 8);
    step();
    chk("drain_e3_full", 32'(full), 0);
    chk("drain_e3_level", 32'(level), 7);
    chk("drain_e3_afull", 32'(afull), 1);
    r_gptr = 4'd3;
    repeat (3) step();
    chk("drain2_level", 32'(level), 6);
    chk("drain2_afull", 32'(afull), 1);
    chk("drain2_full", 32'(full), 0);

    // Wrap: reader consumes each entry right after it is written
    r_gptr = 4'd0;
    reset_pulse();
    inc = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      chk($sformatf("wrap%0d_addr", n),  32'(addr),  32'(n % 8));
      chk($sformatf("wrap%0d_gptr", n),  32'(gptr),  32'(g(4'(n % 16))));
      chk($sformatf("wrap%0d_full", n),  32'(full),  0);
      chk($sformatf("wrap%0d_level", n), 32'(level), 32'((n < 3) ? n : 3));
      r_gptr = g(4'(n % 16));
    end
    inc = 1'b0;

    // Mid-operation asynchronous reset at level 5
    r_gptr = 4'd0;
    reset_pulse();
    inc = 1'b1;
    repeat (5) step();
    chk("mid_level5", 32'(level), 5);
    chk("mid_addr5", 32'(addr), 5);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_async");
    step();
    chk_reset_outputs("mid_hold");
    rst_n = 1'b1;
    chk("resume_addr0", 32'(addr), 0);
    step();
    chk("resume_addr1", 32'(addr), 1);
    chk("resume_level1", 32'(level), 1);
    step();
    chk("resume_level2", 32'(level), 2);
    inc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
